// File: rtl/rpn_pkg.sv
// Shared types for the RPN token executor: opcodes, FSM states, error codes.
package rpn_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_DUP  = 3'd6,
    OP_DROP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_POP1,
    ST_POP2,
    ST_PUSH
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;

  function automatic logic is_binary(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN operator: y = op(a, b), a = entry below top, b = top.
// DUP/DROP pass b through; arithmetic wraps modulo 2^DW.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_e           op,
  output logic [DW-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/rpn_exec.sv
// RPN token executor driving an external stack; one token in flight, tok_ready only in IDLE.
// Number/DUP push 2 cycles after acceptance, binary ops 4 cycles; illegal tokens abort from CHECK.
module rpn_exec
  import rpn_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tok_valid,
  input  logic          tok_is_op,
  input  logic [2:0]    tok_op,
  input  logic [DW-1:0] tok_data,
  output logic          tok_ready,
  output logic          push,
  output logic          pop,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] stack_top,
  input  logic [DW-1:0] stack_next,
  input  logic [5:0]    numcnt,
  input  logic          full,
  input  logic          empty,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

  state_e        state, state_nxt;
  logic          is_op_q;
  op_e           op_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] alu_y;
  logic [1:0]    chk_code;
  logic          stack_full;
  logic          accept;

  assign stack_full = full || (numcnt >= DEPTH_CNT);
  assign accept     = tok_valid && tok_ready;

  rpn_alu #(.DW(DW)) u_alu (
    .a  (stack_next),
    .b  (stack_top),
    .op (op_q),
    .y  (alu_y)
  );

  // Binary ops free two entries before pushing, so a full stack is fine for them.
  always_comb begin
    chk_code = ERR_NONE;
    if (!is_op_q) begin
      if (stack_full) chk_code = ERR_OVERFLOW;
    end else if (is_binary(op_q)) begin
      if (numcnt < 6'd2) chk_code = ERR_UNDERFLOW;
    end else if (empty) begin
      chk_code = ERR_UNDERFLOW;
    end else if (op_q == OP_DUP && stack_full) begin
      chk_code = ERR_OVERFLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (chk_code != ERR_NONE)                state_nxt = ST_IDLE;
        else if (!is_op_q || op_q == OP_DUP)     state_nxt = ST_PUSH;
        else                                     state_nxt = ST_POP1;
      end
      ST_POP1:  state_nxt = (op_q == OP_DROP) ? ST_IDLE : ST_POP2;
      ST_POP2:  state_nxt = ST_PUSH;
      ST_PUSH:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tok_ready    = (state == ST_IDLE) && !rst;
    push         = (state == ST_PUSH) && !rst;
    pop          = (state == ST_POP1 || state == ST_POP2) && !rst;
    result_valid = (state == ST_PUSH) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_op_q  <= 1'b0;
      op_q     <= OP_ADD;
      data_q   <= '0;
      data_in  <= '0;
      result   <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err <= 1'b0;
      if (accept) begin
        is_op_q  <= tok_is_op;
        op_q     <= op_e'(tok_op);
        data_q   <= tok_data;
        err_code <= ERR_NONE;
      end
      if (state == ST_CHECK) begin
        if (chk_code != ERR_NONE) begin
          err      <= 1'b1;
          err_code <= chk_code;
        end else begin
          data_in <= is_op_q ? alu_y : data_q;
        end
      end
      if (state == ST_PUSH) result <= data_in;
    end
  end

endmodule

// File: doc/rpn_exec.md
RPN_EXEC -- requirements
Module: rpn_exec

Interface
REQ-001 SHALL expose parameter DW, default 32, data and operand width.
REQ-002 SHALL expose parameter DEPTH, default 32, stack capacity matching the full threshold.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tok_valid  input  1  token offered.
REQ-006 tok_is_op  input  1  1 = operator token, 0 = number token.
REQ-007 tok_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 DUP, 7 DROP.
REQ-008 tok_data  input  DW  number value; ignored for operators.
REQ-009 tok_ready  output  1  block accepts a token this cycle.
REQ-010 push  output  1  stack push strobe.
REQ-011 pop  output  1  stack pop strobe.
REQ-012 data_in  output  DW  value written on push.
REQ-013 stack_top  input  DW  current top-of-stack.
REQ-014 stack_next  input  DW  entry below top.
REQ-015 numcnt  input  6  stack occupancy.
REQ-016 full  input  1  stack full.
REQ-017 empty  input  1  stack empty.
REQ-018 result  output  DW  last value pushed by this block.
REQ-019 result_valid  output  1  one-cycle pulse coincident with each push.
REQ-020 err  output  1  one-cycle error pulse.
REQ-021 err_code  output  2  0 none, 1 overflow, 2 underflow; held until the next token is accepted.

Function
REQ-022 SHALL accept a token on a rising edge where tok_valid and tok_ready are both 1; tok_ready SHALL be 1 only in state IDLE.
REQ-023 SHALL use states IDLE, CHECK, POP1, POP2, PUSH; every non-IDLE state SHALL last exactly one cycle.
REQ-024 SHALL latch tok_is_op, tok_op and tok_data on acceptance, then go IDLE->CHECK.
REQ-025 In CHECK, SHALL latch a = stack_next and b = stack_top, evaluate legality, and register the ALU result.
REQ-026 Number token: CHECK->PUSH (push = 1, data_in = tok_data); latency from acceptance to push is 2 cycles.
REQ-027 Binary op (0-5): CHECK->POP1->POP2->PUSH, pushing op(a, b); push occurs 4 cycles after acceptance.
REQ-028 Binary op results: SUB = a - b; MUL = low DW bits of a*b; ADD/SUB wrap modulo 2^DW, with no overflow flag.
REQ-029 DUP: CHECK->PUSH with data_in = b.
REQ-030 DROP: CHECK->POP1->IDLE, with no push and no result_valid.
REQ-031 Underflow: numcnt < 2 for a binary op, or empty for DUP/DROP, SHALL cause CHECK->IDLE, err = 1, err_code = 2, and no stack strobes.
REQ-032 Overflow: full for a number or DUP SHALL cause CHECK->IDLE, err = 1, err_code = 1, and no push.
REQ-033 A binary op on a full stack is legal, since it frees entries before pushing.
REQ-034 push and pop SHALL never be asserted in the same cycle; each SHALL be asserted only in its named state.
REQ-035 In PUSH, SHALL update result to the pushed value and pulse result_valid; PUSH->IDLE.
REQ-036 A token held valid while tok_ready = 0 SHALL NOT be consumed or altered by the block.

Reset
REQ-037 With rst = 1 on a clock edge, the block SHALL enter IDLE and set push, pop, result_valid and err to 0, and result, data_in and err_code to 0.
REQ-038 Reset asserted mid-sequence SHALL abort it with no further strobes; the stack is reset by the same rst.
REQ-039 tok_ready SHALL be 0 while rst = 1 and 1 in the first cycle after reset release.

Structure
REQ-040 Package rpn_pkg SHALL hold the opcode enum, the state enum, the err_code constants and the DW default.
REQ-041 The combinational operator evaluation SHALL be a sub-module named rpn_alu, taking a, b and op and returning the result; the FSM remains in rpn_exec.

Verification
REQ-042 Push 5, push 3, SUB -> pushes of 5, then 3, then 2; result = 2; numcnt ends at 1.
REQ-043 Push 0xFFFFFFFF, push 1, ADD -> result 0; push 0x10000, push 0x10000, MUL -> result 0.
REQ-044 Empty stack, ADD -> err pulse, err_code = 2, no push/pop, numcnt stays 0; push 7, DUP, MUL -> result 49.
REQ-045 32 number pushes, then a 33rd -> err_code = 1, numcnt stays 32; ADD -> legal, numcnt 31.
REQ-046 Hold tok_valid through a 5-cycle binary sequence -> tok_ready is low for 4 cycles and the next token is accepted exactly once.
REQ-047 Assert rst during POP2 -> no push follows, tok_ready = 1 after release, outputs at reset values.
